output_layer_sgd: RTL and testbench

Sequential SGD weight updater for the output layer of the network. On a start pulse it captures the loss gradient vector from the cost stage and the previous-layer activations, then walks the output-layer weight memory. For every weight it applies w ← w − lr·δ_j·a_i via a read-modify-write. It consumes the gradient side of the cost stage and is the first step of backpropagation.

---
 rtl/output_layer_sgd_pkg.sv | 22 ++
 rtl/output_layer_sgd_mul.sv | 15 +
 rtl/output_layer_sgd.sv | 173 +++++++++++++++++
 tb/tb_output_layer_sgd.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_layer_sgd_pkg.sv
// Shared Q8.24 fixed-point definitions and FSM states for the output-layer SGD updater.
package output_layer_sgd_pkg;

    localparam int          FX_W    = 32;
    localparam int          FX_FRAC = 24;
    localparam logic [31:0] FX_ONE  = 32'h0100_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCALE,
        ST_RD,
        ST_CALC,
        ST_WR,
        ST_DONE
    } state_e;

    // Keep the sign bit and the 31 bits above the fraction; overflow wraps silently.
    function automatic logic [FX_W-1:0] fx_trunc(input logic [2*FX_W-1:0] p);
        return {p[2*FX_W-1], p[FX_FRAC+FX_W-2:FX_FRAC]};
    endfunction

endpackage

// File: rtl/output_layer_sgd_mul.sv
// Combinational signed 32x32 multiply with Q8.24 truncation.
module fx_mul_q824
    import output_layer_sgd_pkg::*;
(
    input  logic signed [FX_W-1:0] a_i,
    input  logic signed [FX_W-1:0] b_i,
    output logic signed [FX_W-1:0] p_o
);

    logic signed [2*FX_W-1:0] prod;

    assign prod = a_i * b_i;
    assign p_o  = fx_trunc(prod);

endmodule

// File: rtl/output_layer_sgd.sv
// Sequential SGD updater for output-layer weights: w <- w - (lr*delta_j)*a_i via read-modify-write.
// Define OUTPUT_SGD_BIAS_EN to append a bias phase (b_j <- b_j - lr*delta_j) after the weights.
module output_layer_sgd
    import output_layer_sgd_pkg::*;
#(
    parameter int N_OUT = 10,
    parameter int N_IN  = 16,
    parameter int AW    = $clog2(N_OUT*N_IN+N_OUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [32*N_OUT-1:0]   nabla_loss,
    input  logic [32*N_IN-1:0]    activ_prev,
    input  logic [31:0]           lr,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         mem_addr,
    output logic                  mem_rd_en,
    input  logic [31:0]           mem_rd_data,
    output logic                  mem_wr_en,
    output logic [31:0]           mem_wr_data
);

    localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(N_OUT-1);
    localparam logic [IW-1:0] I_LAST = IW'(N_IN-1);

    logic signed [FX_W-1:0] nabla_lane [N_OUT];
    logic signed [FX_W-1:0] activ_lane [N_IN];

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_nabla
            assign nabla_lane[gi] = nabla_loss[FX_W*(N_OUT-1-gi) +: FX_W];
        end
        for (gi = 0; gi < N_IN; gi++) begin : g_activ
            assign activ_lane[gi] = activ_prev[FX_W*gi +: FX_W];
        end
    endgenerate

    state_e                 state_q;
    logic                   busy_q, done_q, rd_en_q, wr_en_q, bias_q;
    logic [AW-1:0]          addr_q;
    logic [FX_W-1:0]        wr_data_q;
    logic signed [FX_W-1:0] delta_q [N_OUT];
    logic signed [FX_W-1:0] activ_q [N_IN];
    logic signed [FX_W-1:0] lr_q, s_q;
    logic [JW-1:0]          j_q;
    logic [IW-1:0]          i_q;

    logic signed [FX_W-1:0] mul_a, mul_b, mul_p, g_d;
    logic [FX_W-1:0]        w_new_d;

    // One multiplier serves both the row scale (lr*delta) and the per-weight product (s*a).
    always_comb begin
        mul_a = lr_q;
        mul_b = delta_q[j_q];
        if (state_q == ST_CALC) begin
            mul_a = s_q;
            mul_b = activ_q[i_q];
        end
    end

    fx_mul_q824 u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    assign g_d     = bias_q ? s_q : mul_p;
    assign w_new_d = mem_rd_data - g_d;

    function automatic logic [AW-1:0] addr_of(input logic b, input logic [JW-1:0] j,
                                              input logic [IW-1:0] i);
        if (b)
            return AW'(N_OUT*N_IN) + AW'(j);
        return AW'(j) * AW'(N_IN) + AW'(i);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            bias_q    <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            lr_q      <= '0;
            s_q       <= '0;
            j_q       <= '0;
            i_q       <= '0;
            for (int k = 0; k < N_OUT; k++) delta_q[k] <= '0;
            for (int k = 0; k < N_IN; k++)  activ_q[k] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        delta_q <= nabla_lane;
                        activ_q <= activ_lane;
                        lr_q    <= lr;
                        j_q     <= '0;
                        i_q     <= '0;
                        bias_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    s_q     <= mul_p;
                    rd_en_q <= 1'b1;
                    addr_q  <= addr_of(bias_q, j_q, i_q);
                    state_q <= ST_RD;
                end
                ST_RD: begin
                    rd_en_q <= 1'b0;
                    state_q <= ST_CALC;
                end
                ST_CALC: begin
                    wr_data_q <= w_new_d;
                    wr_en_q   <= 1'b1;
                    state_q   <= ST_WR;
                end
                ST_WR: begin
                    wr_en_q <= 1'b0;
                    if (!bias_q && i_q != I_LAST) begin
                        i_q     <= i_q + IW'(1);
                        rd_en_q <= 1'b1;
                        addr_q  <= addr_of(1'b0, j_q, i_q + IW'(1));
                        state_q <= ST_RD;
                    end else if (j_q != J_LAST) begin
                        j_q     <= j_q + JW'(1);
                        i_q     <= '0;
                        state_q <= ST_SCALE;
                    end else begin
                        j_q <= '0;
                        i_q <= '0;
`ifdef OUTPUT_SGD_BIAS_EN
                        if (!bias_q) begin
                            bias_q  <= 1'b1;
                            state_q <= ST_SCALE;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
`else
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
`endif
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    bias_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_addr    = addr_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_output_layer_sgd.sv
// Self-checking bench for output_layer_sgd: randomized runs against a plain-arithmetic SGD model.
module tb_output_layer_sgd;

    localparam int N_OUT = 10;
    localparam int N_IN  = 16;
    localparam int AW    = $clog2(N_OUT*N_IN+N_OUT);
    localparam int NW    = N_OUT*N_IN;
    localparam int DEPTH = 1 << AW;
`ifdef OUTPUT_SGD_BIAS_EN
    localparam bit BIAS = 1'b1;
`else
    localparam bit BIAS = 1'b0;
`endif
    localparam int N_WR  = NW + (BIAS ? N_OUT : 0);
    localparam int TOTAL = N_OUT*(1+3*N_IN) + (BIAS ? 4*N_OUT : 0) + 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [32*N_OUT-1:0] nabla_loss;
    logic [32*N_IN-1:0]  activ_prev;
    logic [31:0]         lr;
    logic                busy, done, mem_rd_en, mem_wr_en;
    logic [AW-1:0]       mem_addr;
    logic [31:0]         mem_rd_data, mem_wr_data;

    output_layer_sgd #(.N_OUT(N_OUT), .N_IN(N_IN), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .nabla_loss  (nabla_loss),
        .activ_prev  (activ_prev),
        .lr          (lr),
        .busy        (busy),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Weight memory model: one-cycle read latency, bulk preload on load_req.
    logic [31:0] mem      [DEPTH];
    logic [31:0] init_mem [DEPTH];
    logic [31:0] exp_mem  [DEPTH];
    logic        load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= init_mem[k];
        end else begin
            if (mem_rd_en) mem_rd_data <= mem[mem_addr];
            if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        end
    end

    // Observation of busy length, done position, strobe overlap and the write stream.
    logic        mon_clr = 1'b0;
    int          busy_cnt, done_at, overlap;
    logic [31:0] wq_addr[$], wq_data[$];

    always @(negedge clk) begin
        if (mon_clr) begin
            busy_cnt = 0;
            done_at  = -1;
            overlap  = 0;
            wq_addr.delete();
            wq_data.delete();
        end else begin
            if (busy) begin
                busy_cnt++;
                if (done) done_at = busy_cnt;
            end
            if (mem_rd_en && mem_wr_en) overlap++;
            if (mem_wr_en) begin
                wq_addr.push_back(32'(mem_addr));
                wq_data.push_back(mem_wr_data);
            end
        end
    end

    logic [31:0] d_v [N_OUT];
    logic [31:0] a_v [N_IN];
    logic [31:0] lr_v;

    function automatic logic [31:0] mulq(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return {p[63], p[54:24]};
    endfunction

    task automatic drive_inputs();
        for (int j = 0; j < N_OUT; j++) nabla_loss[32*(N_OUT-1-j) +: 32] = d_v[j];
        for (int i = 0; i < N_IN; i++)  activ_prev[32*i +: 32] = a_v[i];
        lr = lr_v;
    endtask

    task automatic randomize_operands();
        lr_v = $urandom;
        for (int j = 0; j < N_OUT; j++) d_v[j] = $urandom;
        for (int i = 0; i < N_IN; i++)  a_v[i] = $urandom;
        for (int k = 0; k < DEPTH; k++) init_mem[k] = $urandom;
    endtask

    task automatic load_and_clear();
        @(negedge clk);
        #1 load_req = 1'b1;
        mon_clr = 1'b1;
        @(negedge clk);
        #1 load_req = 1'b0;
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_op(input string tag, input bit disturb);
        logic [31:0] ea[$], ed[$];
        int  cyc, bad, adr;
        bit  seen;
        for (int k = 0; k < DEPTH; k++) exp_mem[k] = init_mem[k];
        for (int j = 0; j < N_OUT; j++)
            for (int i = 0; i < N_IN; i++) begin
                adr = j*N_IN + i;
                exp_mem[adr] = init_mem[adr] - mulq(mulq(lr_v, d_v[j]), a_v[i]);
                ea.push_back(32'(adr));
                ed.push_back(exp_mem[adr]);
            end
        if (BIAS)
            for (int j = 0; j < N_OUT; j++) begin
                adr = NW + j;
                exp_mem[adr] = init_mem[adr] - mulq(lr_v, d_v[j]);
                ea.push_back(32'(adr));
                ed.push_back(exp_mem[adr]);
            end

        load_and_clear();
        drive_inputs();
        pulse_start();

        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
            end else if (disturb && busy && (cyc % 37 == 0)) begin
                #1 start = 1'b1;
                nabla_loss = {N_OUT{$urandom}};
                activ_prev = {N_IN{$urandom}};
                lr = $urandom;
            end else begin
                #1 start = 1'b0;
            end
        end
        check_eq({tag, ":done_seen"}, 64'(seen), 64'd1);
        // A start coinciding with done must not relaunch the sequence.
        #1 start = 1'b1;
        @(negedge clk);
        check_eq({tag, ":busy_after_done"}, 64'(busy), 64'd0);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq({tag, ":no_restart"}, 64'(busy), 64'd0);

        check_eq({tag, ":wr_count"}, 64'(wq_addr.size()), 64'(N_WR));
        for (int k = 0; k < wq_addr.size() && k < ea.size(); k++) begin
            check_eq($sformatf("%s:wr_addr[%0d]", tag, k), 64'(wq_addr[k]), 64'(ea[k]));
            check_eq($sformatf("%s:wr_data[%0d]", tag, k), 64'(wq_data[k]), 64'(ed[k]));
        end
        check_eq({tag, ":busy_cycles"}, 64'(busy_cnt), 64'(TOTAL));
        check_eq({tag, ":done_cycle"}, 64'(done_at), 64'(TOTAL));
        check_eq({tag, ":rd_wr_overlap"}, 64'(overlap), 64'd0);
        bad = 0;
        for (int k = 0; k < DEPTH; k++) if (mem[k] !== exp_mem[k]) bad++;
        check_eq({tag, ":mem_final_bad_words"}, 64'(bad), 64'd0);
        $display("run %s: writes=%0d busy_cycles=%0d done_at=%0d", tag, wq_addr.size(), busy_cnt, done_at);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, ":busy"}, 64'(busy), 64'd0);
        check_eq({tag, ":done"}, 64'(done), 64'd0);
        check_eq({tag, ":rd_en"}, 64'(mem_rd_en), 64'd0);
        check_eq({tag, ":wr_en"}, 64'(mem_wr_en), 64'd0);
        check_eq({tag, ":addr"}, 64'(mem_addr), 64'd0);
        check_eq({tag, ":wr_data"}, 64'(mem_wr_data), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        nabla_loss = '0;
        activ_prev = '0;
        lr = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        #1 rst_n = 1'b1;

        // Unit step: 3.0 - 0.5*1.0*2.0 = 2.0; other rows have zero gradient.
        randomize_operands();
        lr_v = 32'h0080_0000;
        for (int j = 0; j < N_OUT; j++) d_v[j] = 32'h0;
        d_v[0] = 32'h0100_0000;
        a_v[0] = 32'h0200_0000;
        init_mem[0] = 32'h0300_0000;
        run_op("unit_step", 1'b0);
        check_eq("unit_step:w0", 64'(mem[0]), 64'h0200_0000);

        // Negative gradient: 0 - 0.5*(-1.0)*1.0 = +0.5.
        randomize_operands();
        lr_v = 32'h0080_0000;
        d_v[0] = 32'hFF00_0000;
        a_v[0] = 32'h0100_0000;
        init_mem[0] = 32'h0000_0000;
        run_op("neg_grad", 1'b0);
        check_eq("neg_grad:w0", 64'(mem[0]), 64'h0080_0000);

        // Two's-complement wrap on the subtraction.
        randomize_operands();
        lr_v = 32'h0100_0000;
        d_v[0] = 32'h7F00_0000;
        a_v[0] = 32'h0100_0000;
        init_mem[0] = 32'h8000_0000;
        run_op("wrap", 1'b0);
        check_eq("wrap:w0", 64'(mem[0]), 64'h0100_0000);

        randomize_operands();
        run_op("rand_a", 1'b0);
        randomize_operands();
        run_op("rand_busy_start", 1'b1);

`ifdef OUTPUT_SGD_BIAS_EN
        randomize_operands();
        lr_v = 32'h0100_0000;
        for (int j = 0; j < N_OUT; j++) begin
            d_v[j] = 32'h0100_0000;
            init_mem[NW+j] = 32'h0;
        end
        run_op("bias", 1'b0);
        for (int j = 0; j < N_OUT; j++)
            check_eq($sformatf("bias:b[%0d]", j), 64'(mem[NW+j]), 64'hFF00_0000);
`endif

        // Asynchronous reset mid-operation clears outputs without waiting for a clock.
        randomize_operands();
        load_and_clear();
        drive_inputs();
        pulse_start();
        repeat (100) @(negedge clk);
        check_eq("mid_reset:busy_before", 64'(busy), 64'd1);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("mid_reset");
        @(negedge clk);
        #1 rst_n = 1'b1;

        randomize_operands();
        run_op("after_reset", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
